// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: op-codes, FSM states and default width.
package ex_pkg;

   localparam int DATA_W_DEF = 16;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_SHL  = 4'd5;
   localparam logic [3:0] OP_SHR  = 4'd6;
   localparam logic [3:0] OP_SLT  = 4'd7;
   localparam logic [3:0] OP_MUL  = 4'd8;
   localparam logic [3:0] OP_PASS = 4'd9;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } ex_state_e;

endpackage

// File: rtl/ex_mul.sv
// Iterative shift-add multiplier: one partial product per cycle, low DATA_W bits kept.
// done and product are valid together during the final iteration cycle.
module ex_mul #(
   parameter int DATA_W     = 16,
   parameter int MUL_CYCLES = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic              done,
   output logic [DATA_W-1:0] product
);

   localparam logic [4:0] CNT_LAST = 5'(MUL_CYCLES - 1);

   logic              active_r;
   logic [4:0]        cnt_r;
   logic [DATA_W-1:0] mcand_r;
   logic [DATA_W-1:0] mplier_r;
   logic [DATA_W-1:0] acc_r;
   logic [DATA_W-1:0] addend_s;
   logic [DATA_W-1:0] sum_s;

   assign addend_s = mplier_r[0] ? mcand_r : {DATA_W{1'b0}};
   assign sum_s    = acc_r + addend_s;
   assign done     = active_r && (cnt_r == CNT_LAST);
   assign product  = sum_s;

   // Operand load on start, then one shift-add iteration per cycle until the last.
   always_ff @(posedge clk) begin
      if (rst) begin
         active_r <= 1'b0;
         cnt_r    <= 5'd0;
         mcand_r  <= {DATA_W{1'b0}};
         mplier_r <= {DATA_W{1'b0}};
         acc_r    <= {DATA_W{1'b0}};
      end else if (start) begin
         active_r <= 1'b1;
         cnt_r    <= 5'd0;
         mcand_r  <= a;
         mplier_r <= b;
         acc_r    <= {DATA_W{1'b0}};
      end else if (active_r) begin
         acc_r    <= sum_s;
         mcand_r  <= mcand_r << 1;
         mplier_r <= mplier_r >> 1;
         if (done) begin
            active_r <= 1'b0;
            cnt_r    <= 5'd0;
         end else begin
            cnt_r    <= cnt_r + 5'd1;
         end
      end
   end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU plus an iterative multiplier behind a
// valid/ready handshake with a one-entry registered output.
module ex_stage
   import ex_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DEF,
   parameter int MUL_CYCLES = DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic              is_store,
   input  logic [DATA_W-1:0] store_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] result,
   output logic [DATA_W-1:0] rd,
   output logic              mem_w,
   output logic              busy
);

   ex_state_e         state_r;
   ex_state_e         state_next_s;
   logic              accept_s;
   logic              is_mul_s;
   logic              mul_start_s;
   logic              mul_done_s;
   logic [DATA_W-1:0] alu_s;
   logic [DATA_W-1:0] product_s;
   logic [DATA_W-1:0] result_r;
   logic [DATA_W-1:0] rd_r;
   logic              out_valid_r;
   logic              mem_w_r;
   logic              busy_r;

   // A multiply may only start when the output slot is empty or draining this edge.
   assign in_ready    = !rst && (state_r == ST_IDLE) && (!out_valid_r || out_ready);
   assign accept_s    = in_valid && in_ready;
   assign is_mul_s    = (op == OP_MUL) && !is_store;
   assign mul_start_s = accept_s && is_mul_s;

   assign out_valid = out_valid_r;
   assign result    = result_r;
   assign rd        = rd_r;
   assign mem_w     = mem_w_r;
   assign busy      = busy_r;

   ex_mul #(
      .DATA_W    (DATA_W),
      .MUL_CYCLES(MUL_CYCLES)
   ) u_mul (
      .clk    (clk),
      .rst    (rst),
      .start  (mul_start_s),
      .a      (a),
      .b      (b),
      .done   (mul_done_s),
      .product(product_s)
   );

   // Single-cycle ALU; a store forces address generation regardless of op.
   always_comb begin
      alu_s = {DATA_W{1'b0}};
      if (is_store) begin
         alu_s = a + b;
      end else begin
         case (op)
            OP_ADD:  alu_s = a + b;
            OP_SUB:  alu_s = a - b;
            OP_AND:  alu_s = a & b;
            OP_OR:   alu_s = a | b;
            OP_XOR:  alu_s = a ^ b;
            OP_SHL:  alu_s = a << b[3:0];
            OP_SHR:  alu_s = a >> b[3:0];
            OP_SLT:  alu_s = ($signed(a) < $signed(b)) ? {{(DATA_W-1){1'b0}}, 1'b1}
                                                       : {DATA_W{1'b0}};
            OP_PASS: alu_s = b;
            default: alu_s = {DATA_W{1'b0}};
         endcase
      end
   end

   // Next-state logic for the IDLE/MUL controller.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (mul_start_s) begin
               state_next_s = ST_MUL;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_MUL: begin
            if (mul_done_s) begin
               state_next_s = ST_IDLE;
            end else begin
               state_next_s = ST_MUL;
            end
         end
         default: state_next_s = ST_IDLE;
      endcase
   end

   // State register and registered busy flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_next_s;
         busy_r  <= (state_next_s == ST_MUL);
      end
   end

   // Output slot: load on single-cycle accept or multiply completion, clear on drain.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_r <= 1'b0;
         mem_w_r     <= 1'b0;
         result_r    <= {DATA_W{1'b0}};
         rd_r        <= {DATA_W{1'b0}};
      end else if (accept_s && !is_mul_s) begin
         out_valid_r <= 1'b1;
         mem_w_r     <= is_store;
         result_r    <= alu_s;
         rd_r        <= is_store ? store_data : {DATA_W{1'b0}};
      end else if (mul_done_s) begin
         out_valid_r <= 1'b1;
         mem_w_r     <= 1'b0;
         result_r    <= product_s;
         rd_r        <= {DATA_W{1'b0}};
      end else if (out_ready) begin
         out_valid_r <= 1'b0;
         mem_w_r     <= 1'b0;
      end
   end

endmodule
